// File: rtl/hwag_div_scheduler.sv
// hwag_div_scheduler
//   Shares one sequential integer divider between NREQ requesters. Each
//   request snapshots its dividend/divisor. A round-robin arbiter picks the
//   next pending slot, drives the divider, and returns the quotient and
//   remainder into that slot with a one-cycle done pulse.
//
// Optional build macro:
//   HWAG_DIV_SCHED_PRIO_EN  fixed priority (lowest index wins) instead of
//                           round-robin.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req[NREQ]                    request pulses, operands sampled same cycle
//   dividend_bus, divider_bus    packed operands, slot i at [i*WIDTH +: WIDTH]
//   div_start                    one-cycle start pulse to the divider
//   div_dividend, div_divider    registered operands to the divider
//   div_rdy                      divider ready / result-valid level
//   div_result, div_remainder    divider outputs
//   res_bus, rem_bus             held quotient / remainder per slot
//   done[NREQ]                   one-hot pulse when a slot is updated
//   dz[NREQ], tmo[NREQ]          slot's last op was divide-by-zero / timed out
//   busy                         scheduler not idle
module hwag_div_scheduler #(
  parameter int WIDTH = 24,
  parameter int NREQ  = 2,
  parameter int TMO_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] dividend_bus,
  input  logic [NREQ*WIDTH-1:0] divider_bus,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divider,
  input  logic                  div_rdy,
  input  logic [WIDTH-1:0]      div_result,
  input  logic [WIDTH-1:0]      div_remainder,
  output logic [NREQ*WIDTH-1:0] res_bus,
  output logic [NREQ*WIDTH-1:0] rem_bus,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       dz,
  output logic [NREQ-1:0]       tmo,
  output logic                  busy
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);
  // Last WAIT cycle before giving up: the counter reaches all-ones on this edge.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ZERO,
    S_START,
    S_WAIT
  } state_t;

  state_t           state;
  logic [NREQ-1:0]  pending;
  logic [WIDTH-1:0] snap_dvd [NREQ];
  logic [WIDTH-1:0] snap_dvs [NREQ];
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    cur;
  logic [TMO_W-1:0] tmo_cnt;

  logic             grant_any;
  logic [IW-1:0]    grant_idx;
  logic [NREQ-1:0]  clr;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    clr       = '0;
`ifdef HWAG_DIV_SCHED_PRIO_EN
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!grant_any && pending[IW'(k)]) begin
        grant_any = 1'b1;
        grant_idx = IW'(k);
      end
    end
`else
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!grant_any && pending[IW'((32'(ptr) + k) % NREQ)]) begin
        grant_any = 1'b1;
        grant_idx = IW'((32'(ptr) + k) % NREQ);
      end
    end
`endif
    if (state == S_IDLE && grant_any) clr[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pending      <= '0;
      ptr          <= PTR_RST;
      cur          <= '0;
      tmo_cnt      <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        snap_dvd[IW'(i)] <= '0;
        snap_dvs[IW'(i)] <= '0;
      end
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divider  <= '0;
      res_bus      <= '0;
      rem_bus      <= '0;
      done         <= '0;
      dz           <= '0;
      tmo          <= '0;
      busy         <= 1'b0;
    end else begin
      done      <= '0;
      div_start <= 1'b0;

      // A new request in the grant cycle re-arms the slot: set wins over clear.
      pending <= (pending & ~clr) | req;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req[IW'(i)]) begin
          snap_dvd[IW'(i)] <= dividend_bus[i*WIDTH +: WIDTH];
          snap_dvs[IW'(i)] <= divider_bus[i*WIDTH +: WIDTH];
        end
      end

      case (state)
        S_IDLE: begin
          if (grant_any) begin
            cur          <= grant_idx;
            ptr          <= grant_idx;
            div_dividend <= snap_dvd[grant_idx];
            div_divider  <= snap_dvs[grant_idx];
            busy         <= 1'b1;
            if (snap_dvs[grant_idx] == '0) begin
              state <= S_ZERO;
            end else begin
              state     <= S_START;
              div_start <= 1'b1;
            end
          end
        end

        S_ZERO: begin
          res_bus[cur*WIDTH +: WIDTH] <= '1;
          rem_bus[cur*WIDTH +: WIDTH] <= div_dividend;
          dz[cur]   <= 1'b1;
          tmo[cur]  <= 1'b0;
          done[cur] <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end

        S_START: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end

        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // tmo_cnt == 0 marks the first WAIT cycle, where div_rdy may still
          // reflect the previous operation.
          if (tmo_cnt != '0 && div_rdy) begin
            res_bus[cur*WIDTH +: WIDTH] <= div_result;
            rem_bus[cur*WIDTH +: WIDTH] <= div_remainder;
            dz[cur]   <= 1'b0;
            tmo[cur]  <= 1'b0;
            done[cur] <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            dz[cur]   <= 1'b0;
            tmo[cur]  <= 1'b1;
            done[cur] <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwag_div_scheduler.sv
// Self-checking bench for hwag_div_scheduler: directed latency/arbitration
// cases followed by randomized requests, with a scoreboard monitor that checks
// every done pulse against expectations pushed when requests are issued.
module tb_hwag_div_scheduler;

  localparam int W  = 24;
  localparam int N  = 2;
  localparam int TW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] dividend_bus = '0;
  logic [N*W-1:0] divider_bus  = '0;
  logic           div_start;
  logic [W-1:0]   div_dividend;
  logic [W-1:0]   div_divider;
  logic           div_rdy = 1'b0;
  logic [W-1:0]   div_result = '0;
  logic [W-1:0]   div_remainder = '0;
  logic [N*W-1:0] res_bus;
  logic [N*W-1:0] rem_bus;
  logic [N-1:0]   done;
  logic [N-1:0]   dz;
  logic [N-1:0]   tmo;
  logic           busy;

  hwag_div_scheduler #(.WIDTH(W), .NREQ(N), .TMO_W(TW)) dut (
    .clk(clk), .rst(rst), .req(req),
    .dividend_bus(dividend_bus), .divider_bus(divider_bus),
    .div_start(div_start), .div_dividend(div_dividend), .div_divider(div_divider),
    .div_rdy(div_rdy), .div_result(div_result), .div_remainder(div_remainder),
    .res_bus(res_bus), .rem_bus(rem_bus), .done(done), .dz(dz), .tmo(tmo),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Divider model: result appears `lat` cycles after the start is sampled;
  // rdy is left high from the previous op through the first WAIT cycle.
  int           lat  = 4;
  bit           hang = 1'b0;
  int           mcnt = 0;
  logic [W-1:0] mq = '0;
  logic [W-1:0] mr = '0;
  always @(posedge clk) begin
    if (div_start) begin
      if (div_divider != '0) begin
        mq <= div_dividend / div_divider;
        mr <= div_dividend % div_divider;
      end else begin
        mq <= '1;
        mr <= div_dividend;
      end
      mcnt <= lat;
    end else if (mcnt != 0) begin
      if (hang) begin
        div_rdy <= 1'b0;
        mcnt    <= 0;
      end else if (mcnt == 1) begin
        div_rdy       <= 1'b1;
        div_result    <= mq;
        div_remainder <= mr;
        mcnt          <= 0;
      end else begin
        div_rdy <= 1'b0;
        mcnt    <= mcnt - 1;
      end
    end
  end

  // Scoreboard
  typedef struct {
    int           slot;
    logic [W-1:0] res;
    logic [W-1:0] rem;
    bit           dz;
    bit           tmo;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] held_res [N];
  logic [W-1:0] held_rem [N];

  task automatic push_exp(input int s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.slot = s;
    e.tmo  = 1'b0;
    if (b == '0) begin
      e.res = '1;
      e.rem = a;
      e.dz  = 1'b1;
    end else begin
      e.res = a / b;
      e.rem = a % b;
      e.dz  = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic push_tmo(input int s);
    exp_t e;
    e.slot = s;
    e.res  = '0;
    e.rem  = '0;
    e.dz   = 1'b0;
    e.tmo  = 1'b1;
    sb.push_back(e);
  endtask

  function automatic bit outstanding(input int s);
    foreach (sb[k]) if (sb[k].slot == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_slot(input int s);
    int   idx;
    exp_t e;
    idx = -1;
    foreach (sb[k]) if (idx < 0 && sb[k].slot == s) idx = k;
    if (idx < 0) begin
      fail_now($sformatf("unexpected_done slot%0d", s));
      return;
    end
    e = sb[idx];
    sb.delete(idx);
    if (!e.tmo) begin
      held_res[s] = e.res;
      held_rem[s] = e.rem;
    end
    chk($sformatf("res slot%0d", s), res_bus[s*W +: W], held_res[s]);
    chk($sformatf("rem slot%0d", s), rem_bus[s*W +: W], held_rem[s]);
    chk($sformatf("dz slot%0d", s),  dz[s],  e.dz);
    chk($sformatf("tmo slot%0d", s), tmo[s], e.tmo);
  endtask

  int n_starts   = 0;
  int last_start = -1;
  always @(negedge clk) begin
    if (div_start) begin
      n_starts++;
      last_start = cyc;
    end
    if (!rst && done != '0) begin
      chk("done_onehot", $onehot(done), 1);
      for (int i = 0; i < N; i++) if (done[i]) check_slot(i);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int s, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    dividend_bus[s*W +: W] = a;
    divider_bus[s*W +: W]  = b;
    req[s] = 1'b1;
    if (push) push_exp(s, a, b);
  endtask

  task automatic wait_done(input int s, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done[s]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) fail_now($sformatf("wait_done slot%0d timed out", s));
  endtask

  task automatic wait_any(input int budget, output int s, output int at);
    at = -1;
    s  = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done != '0) begin
        at = cyc;
        s  = done[0] ? 0 : 1;
        break;
      end
    end
    if (at < 0) fail_now("wait_any timed out");
  endtask

  task automatic clear_model;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      held_res[i] = '0;
      held_rem[i] = '0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  int c0, at, s1, d1, s2, d2, st0, rb_first;
  logic [W-1:0] a, b;

  initial begin
    clear_model();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", res_bus, 0);
    chk("rst_rem", rem_bus, 0);
    chk("rst_flags", {dz, tmo}, 0);
    chk("rst_div_if", {div_start, div_dividend, div_divider}, 0);
    rst = 1'b0;
    tick();

    // Both slots in one cycle, fresh pointer: slot 0 first, one IDLE gap.
    lat = 4;
    c0 = cyc;
    set_op(0, 24'd700007, 24'd7, 1'b1);
    set_op(1, 24'd123456, 24'd7, 1'b1);
    tick();
    req = '0;
    wait_any(60, s1, d1);
    chk("rrA_first_slot", s1, 0);
    chk("rrA_first_cycle", d1, c0 + 8);
    wait_any(60, s2, d2);
    chk("rrA_second_slot", s2, 1);
    chk("rrA_second_cycle", d2, d1 + 7);
    tick();

    // Single request latency.
    c0 = cyc;
    set_op(0, 24'd3125000, 24'd1000, 1'b1);
    tick();
    req = '0;
    wait_done(0, 40, at);
    chk("t1_start_cycle", last_start, c0 + 2);
    chk("t1_done_cycle", at, c0 + 8);
    chk("t1_res", res_bus[W-1:0], 3125);
    chk("t1_rem", rem_bus[W-1:0], 0);
    tick();

    // Both again after slot 0 was served last: round-robin favours slot 1.
`ifdef HWAG_DIV_SCHED_PRIO_EN
    rb_first = 0;
`else
    rb_first = 1;
`endif
    set_op(0, 24'd99, 24'd7, 1'b1);
    set_op(1, 24'd4242, 24'd7, 1'b1);
    tick();
    req = '0;
    wait_any(60, s1, d1);
    chk("rrB_first_slot", s1, rb_first);
    wait_any(60, s2, d2);
    chk("rrB_second_slot", s2, 1 - rb_first);
    chk("rrB_gap", d2, d1 + 7);
    tick();

    // Divide by zero.
    st0 = n_starts;
    c0 = cyc;
    set_op(1, 24'd50000, 24'd0, 1'b1);
    tick();
    req = '0;
    wait_done(1, 20, at);
    chk("zero_done_cycle", at, c0 + 3);
    chk("zero_dz", dz[1], 1);
    chk("zero_res", res_bus[2*W-1:W], 24'hFFFFFF);
    chk("zero_no_start", n_starts - st0, 0);
    tick();

    // Timeout: divider never answers.
    hang = 1'b1;
    c0 = cyc;
    set_op(0, 24'd1234, 24'd5, 1'b0);
    push_tmo(0);
    tick();
    req = '0;
    wait_done(0, 60, at);
    chk("tmo_start_cycle", last_start, c0 + 2);
    chk("tmo_done_cycle", at, last_start + 16);
    chk("tmo_flag", tmo[0], 1);
    hang = 1'b0;
    tick();
    set_op(0, 24'd999, 24'd10, 1'b1);
    tick();
    req = '0;
    wait_done(0, 40, at);
    chk("tmo_recover_flag", tmo[0], 0);
    tick();

    // Coalescing: slot 0 requested twice while waiting behind slot 1.
    st0 = n_starts;
    set_op(1, 24'd8000, 24'd3, 1'b1);
    tick();
    req = '0;
    set_op(0, 24'd7777, 24'd3, 1'b0);
    tick();
    set_op(0, 24'd100, 24'd10, 1'b1);
    tick();
    req = '0;
    wait_done(0, 60, at);
    repeat (30) tick();
    chk("coalesce_starts", n_starts - st0, 2);
    chk("coalesce_res", res_bus[W-1:0], 10);

    // Reset in the middle of WAIT.
    lat = 8;
    set_op(0, 24'd5000, 24'd7, 1'b1);
    tick();
    req = '0;
    repeat (4) tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    clear_model();
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res", res_bus, 0);
    chk("mid_rst_rem", rem_bus, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_start", div_start, 0);
    repeat (20) tick();
    lat = 3;
    set_op(1, 24'd65535, 24'd255, 1'b1);
    tick();
    req = '0;
    wait_done(1, 40, at);
    tick();

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      for (int s = 0; s < N; s++) begin
        if (!outstanding(s) && $urandom_range(0, 3) == 0) begin
          a = W'($urandom);
          case ($urandom_range(0, 7))
            0:       b = '0;
            1, 2, 3: b = W'($urandom_range(1, 15));
            default: b = W'($urandom);
          endcase
          set_op(s, a, b, 1'b1);
        end
      end
      lat = $urandom_range(1, 8);
      tick();
      req = '0;
    end

    for (int k = 0; k < 600; k++) begin
      if (sb.size() == 0) break;
      tick();
    end
    if (sb.size() != 0) fail_now($sformatf("drain: %0d results missing", sb.size()));
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
